apb_timer_arbiter: RTL

- Two-requester round-robin arbiter and APB master sequencer in front of the timer's APB slave port (timer_top).
- Lets two software agents share the single timer register interface, for example a CPU bridge and a DMA/auto-reload engine.
- Each requester uses a simple valid/done handshake; the block generates compliant APB SETUP/ACCESS phases.
- A bounded pready timeout reports an error instead of hanging the bus.

---
 rtl/apb_timer_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/apb_timer_arbiter.sv
// apb_timer_arbiter: round-robin arbiter for two requesters sharing one APB
// master port in front of the timer register block. Each requester presents a
// valid/done handshake; the winner's transfer is sequenced as APB SETUP then
// ACCESS, with an optional bounded wait on pready that aborts with an error.
//
// Ports:
//   pclk, presetn          clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata   requester N request (held until reqN_done)
//   reqN_done/err/rdata    requester N one-cycle completion, error, read data
//   psel/penable/pwrite/paddr/pwdata/prdata/pready   APB master interface
//   grant_id               requester owning the current/last transfer
//   busy                   high while in SETUP or ACCESS
module apb_timer_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              grant_id,
  output logic              busy
);

  localparam int unsigned CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;

  // A requester seeing its own done this cycle is still holding the old
  // request, so it must not be granted again yet.
  logic w_elig0;
  logic w_elig1;
  logic w_any;
  logic w_pick;
  assign w_elig0 = req0_valid & ~req0_done;
  assign w_elig1 = req1_valid & ~req1_done;
  assign w_any   = w_elig0 | w_elig1;
  assign w_pick  = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

  // Winner's request fields
  logic              w_win_write;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  assign w_win_write = w_pick ? req1_write : req0_write;
  assign w_win_addr  = w_pick ? req1_addr  : req0_addr;
  assign w_win_wdata = w_pick ? req1_wdata : req0_wdata;

  // Completion: normal on pready, abort when the wait budget is spent
  logic              w_timeout;
  logic              w_finish;
  logic [DATA_W-1:0] w_rdata;
  assign w_timeout = TO_EN & (r_cnt == CNT_W'(CNT_LAST));
  assign w_finish  = pready | w_timeout;
  assign w_rdata   = (pready & ~pwrite) ? prdata : '0;

  // Arbitration FSM and APB sequencing, all outputs registered
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      req0_done    <= 1'b0;
      req0_err     <= 1'b0;
      req0_rdata   <= '0;
      req1_done    <= 1'b0;
      req1_err     <= 1'b0;
      req1_rdata   <= '0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            pwrite       <= w_win_write;
            paddr        <= w_win_addr;
            pwdata       <= w_win_wdata;
            grant_id     <= w_pick;
            r_last_grant <= w_pick;
            psel         <= 1'b1;
            penable      <= 1'b0;
            busy         <= 1'b1;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_finish) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
            if (grant_id) begin
              req1_done  <= 1'b1;
              req1_err   <= ~pready;
              req1_rdata <= w_rdata;
            end else begin
              req0_done  <= 1'b1;
              req0_err   <= ~pready;
              req0_rdata <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
